// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: word width, reset vector, NOP encoding and the
// {pc, instr} entry carried from fetch to decode.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// In-order buffer of fetched {pc, instr} entries with flush and occupancy count.
module fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           flush_in,
  input  logic                           push_in,
  input  fetch_entry_t                   push_data_in,
  input  logic                           pop_in,
  output fetch_entry_t                   head_out,
  output logic [$clog2(DEPTH+1)-1:0]     count_out,
  output logic                           empty_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_in) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_in)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push_in) - CNT_W'(pop_in);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only: never reset, written only on an unflushed push.
  always_ff @(posedge clk_in) begin
    if (push_in && !flush_in) mem_q[wr_ptr_q] <= push_data_in;
  end

  assign head_out  = mem_q[rd_ptr_q];
  assign count_out = count_q;
  assign empty_out = (count_q == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: PC, credit-limited imem requests, redirect flush/drop.
// Optional misaligned-redirect trap enabled by defining IFU_MISALIGN_TRAP_EN.
module instruction_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_VECTOR,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk_in,
  input  logic            rst_in,
  output logic            imem_req_out,
  output logic [XLEN-1:0] imem_addr_out,
  input  logic            imem_gnt_in,
  input  logic            imem_rvalid_in,
  input  logic [XLEN-1:0] imem_rdata_in,
  input  logic            redirect_in,
  input  logic [XLEN-1:0] redirect_pc_in,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic            valid_out,
  input  logic            ready_in
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  output logic            fault_out
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
`ifdef IFU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [XLEN-1:0]  last_pc_q, last_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             fault_q, fault_d;

  logic             grant, misaligned;
  logic             fifo_push, fifo_pop, fifo_flush, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     push_entry, fifo_head;
  logic [XLEN-1:0]  target_pc;

  // Outstanding requests plus buffered words never exceed the buffer size,
  // so every response always has a slot waiting for it.
  assign imem_req_out  = !rst_in && !redirect_in && !fault_q &&
                         (({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_C);
  assign imem_addr_out = fetch_pc_q;
  assign grant         = imem_req_out && imem_gnt_in;
  assign target_pc     = align_pc(redirect_pc_in);
  assign misaligned    = TRAP_EN && (redirect_pc_in[1:0] != 2'b00);

  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    resp_pc_d        = resp_pc_q;
    last_pc_d        = last_pc_q;
    drop_d           = drop_q;
    fault_d          = fault_q;
    fifo_push        = 1'b0;
    fifo_pop         = 1'b0;
    fifo_flush       = 1'b0;
    push_entry.pc    = resp_pc_q;
    push_entry.instr = imem_rdata_in;
    outstanding_d    = outstanding_q + CNT_W'(grant) - CNT_W'(imem_rvalid_in);
    if (grant) fetch_pc_d = pc_next(fetch_pc_q);
    if (redirect_in) begin
      // Everything still in flight after this cycle belongs to the old path.
      fifo_flush = 1'b1;
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      drop_d     = outstanding_d;
      fault_d    = misaligned;
      if (misaligned) last_pc_d = redirect_pc_in;
    end else begin
      if (imem_rvalid_in) begin
        if (drop_q != '0) begin
          drop_d = drop_q - 1'b1;
        end else begin
          fifo_push = 1'b1;
          resp_pc_d = pc_next(resp_pc_q);
        end
      end
      if (valid_out && ready_in) begin
        fifo_pop  = 1'b1;
        last_pc_d = fifo_head.pc;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      last_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      fault_q       <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      last_pc_q     <= last_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      fault_q       <= fault_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fetch_fifo (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .flush_in     (fifo_flush),
    .push_in      (fifo_push),
    .push_data_in (push_entry),
    .pop_in       (fifo_pop),
    .head_out     (fifo_head),
    .count_out    (fifo_count),
    .empty_out    (fifo_empty)
  );

  assign valid_out = !fifo_empty;
  assign instr_out = fifo_empty ? NOP_INSTR : fifo_head.instr;
  assign pc_out    = fifo_empty ? last_pc_q : fifo_head.pc;
`ifdef IFU_MISALIGN_TRAP_EN
  assign fault_out = fault_q;
`endif

  rvalid_has_request: assert property (@(posedge clk_in) disable iff (rst_in)
    imem_rvalid_in |-> (outstanding_q != '0));

endmodule
